soul_box_mover: RTL and testbench

- Parametrised successor to the single-pixel mover: moves a SPRITE_W x SPRITE_H solid sprite (the player soul) inside a configurable battle box on the 160x120 VGA frame buffer.
- Each frame tick it erases the sprite at its old position, applies key motion with STEP-pixel steps and box clamping, then redraws the sprite.
- Outputs x/y/colour/plot drive the vga_adapter plot port directly.
- A plot-rate handshake (busy) lets a future arbiter share the adapter with other drawers.

---
 rtl/soul_box_mover_if.sv | 15 +
 rtl/soul_box_mover.sv | 158 +++++++++++++++
 tb/tb_soul_box_mover.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/soul_box_mover_if.sv
// Plot port toward the vga_adapter: one pixel write per cycle while plot is high.
// busy tells a future arbiter that this drawer owns the port.
interface soul_box_mover_if #(
   parameter int X_BITS = 8,
   parameter int Y_BITS = 7
);
   logic [X_BITS-1:0] x;
   logic [Y_BITS-1:0] y;
   logic [2:0]        colour;
   logic              plot;
   logic              busy;

   modport master (output x, y, colour, plot, busy);
   modport slave  (input  x, y, colour, plot, busy);
endinterface

// File: rtl/soul_box_mover.sv
// Moves a solid SPRITE_W x SPRITE_H sprite inside a box: erase, step+clamp, redraw per tick.
// Latency: first erase plot 1 cycle after trigger, 2*W*H+1 cycles per move; no backpressure, busy flags ownership.
module soul_box_mover #(
   parameter int          X_BITS    = 8,
   parameter int          Y_BITS    = 7,
   parameter int          SPRITE_W  = 4,
   parameter int          SPRITE_H  = 4,
   parameter int          BOX_X0    = 40,
   parameter int          BOX_X1    = 119,
   parameter int          BOX_Y0    = 50,
   parameter int          BOX_Y1    = 109,
   parameter int          START_X   = 78,
   parameter int          START_Y   = 78,
   parameter int          STEP      = 1,
   parameter int          TICK_DIV  = 833333,
   parameter logic [2:0]  FG_COLOUR = 3'b100,
   parameter logic [2:0]  BG_COLOUR = 3'b000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [3:0]         controlkey,
   soul_box_mover_if.master   plot_bus,
   output logic [X_BITS-1:0]  pos_x,
   output logic [Y_BITS-1:0]  pos_y
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic signed [X_BITS:0] XMIN  = (X_BITS+1)'(BOX_X0);
   localparam logic signed [X_BITS:0] XMAX  = (X_BITS+1)'(BOX_X1 - SPRITE_W + 1);
   localparam logic signed [X_BITS:0] XSTEP = (X_BITS+1)'(STEP);
   localparam logic signed [Y_BITS:0] YMIN  = (Y_BITS+1)'(BOX_Y0);
   localparam logic signed [Y_BITS:0] YMAX  = (Y_BITS+1)'(BOX_Y1 - SPRITE_H + 1);
   localparam logic signed [Y_BITS:0] YSTEP = (Y_BITS+1)'(STEP);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ERASE, S_UPDATE, S_DRAW} state_t;

   state_t            r_state;
   logic [TW-1:0]     r_tick_cnt;
   logic              r_pending;
   logic [3:0]        r_cx;
   logic [3:0]        r_cy;
   logic [X_BITS-1:0] r_pos_x;
   logic [Y_BITS-1:0] r_pos_y;
   logic [X_BITS-1:0] r_x;
   logic [Y_BITS-1:0] r_y;
   logic [2:0]        r_colour;
   logic              r_plot;
   logic              r_busy;

   logic                     w_tick_wrap;
   logic                     w_tick;
   logic                     w_right, w_down, w_up, w_left, w_any_key;
   logic                     w_last_col, w_last_row;
   logic signed [X_BITS:0]   w_dx, w_nx;
   logic signed [Y_BITS:0]   w_dy, w_ny;
   logic [X_BITS-1:0]        w_new_x;
   logic [Y_BITS-1:0]        w_new_y;

   assign w_tick_wrap = (r_tick_cnt == TW'(TICK_DIV - 1));
   assign w_tick      = enable && w_tick_wrap;

   assign w_right   = ~controlkey[0];
   assign w_down    = ~controlkey[1];
   assign w_up      = ~controlkey[2];
   assign w_left    = ~controlkey[3];
   assign w_any_key = (controlkey != 4'b1111);

   assign w_last_col = (r_cx == 4'(SPRITE_W - 1));
   assign w_last_row = (r_cy == 4'(SPRITE_H - 1));

   // One extra sign bit so a step left/up from a small coordinate clamps instead of wrapping.
   always_comb begin
      w_dx = '0;
      w_dy = '0;
      if (w_right && !w_left)      w_dx = XSTEP;
      else if (w_left && !w_right) w_dx = -XSTEP;
      if (w_down && !w_up)         w_dy = YSTEP;
      else if (w_up && !w_down)    w_dy = -YSTEP;
      w_nx = $signed({1'b0, r_pos_x}) + w_dx;
      w_ny = $signed({1'b0, r_pos_y}) + w_dy;
      w_new_x = w_nx[X_BITS-1:0];
      w_new_y = w_ny[Y_BITS-1:0];
      if (w_nx < XMIN)      w_new_x = XMIN[X_BITS-1:0];
      else if (w_nx > XMAX) w_new_x = XMAX[X_BITS-1:0];
      if (w_ny < YMIN)      w_new_y = YMIN[Y_BITS-1:0];
      else if (w_ny > YMAX) w_new_y = YMAX[Y_BITS-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset || w_tick_wrap) r_tick_cnt <= '0;
      else                      r_tick_cnt <= r_tick_cnt + TW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_INIT;
         r_pending <= 1'b0;
         r_cx      <= '0;
         r_cy      <= '0;
         r_pos_x   <= X_BITS'(START_X);
         r_pos_y   <= Y_BITS'(START_Y);
         r_x       <= '0;
         r_y       <= '0;
         r_colour  <= BG_COLOUR;
         r_plot    <= 1'b0;
         r_busy    <= 1'b1;
      end else begin
         case (r_state)
            S_INIT, S_ERASE, S_DRAW: begin
               r_plot   <= 1'b1;
               r_x      <= r_pos_x + X_BITS'(r_cx);
               r_y      <= r_pos_y + Y_BITS'(r_cy);
               r_colour <= (r_state == S_ERASE) ? BG_COLOUR : FG_COLOUR;
               if (w_tick) r_pending <= 1'b1;
               if (w_last_col) begin
                  r_cx <= '0;
                  if (w_last_row) begin
                     r_cy    <= '0;
                     r_state <= (r_state == S_ERASE) ? S_UPDATE : S_IDLE;
                  end else begin
                     r_cy <= r_cy + 4'd1;
                  end
               end else begin
                  r_cx <= r_cx + 4'd1;
               end
            end
            S_UPDATE: begin
               r_plot  <= 1'b0;
               r_pos_x <= w_new_x;
               r_pos_y <= w_new_y;
               r_state <= S_DRAW;
               if (w_tick) r_pending <= 1'b1;
            end
            S_IDLE: begin
               r_plot <= 1'b0;
               // busy drops one cycle after the last draw plot so it covers every write.
               if ((w_tick || r_pending) && w_any_key) begin
                  r_state   <= S_ERASE;
                  r_pending <= 1'b0;
                  r_busy    <= 1'b1;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign plot_bus.x      = r_x;
   assign plot_bus.y      = r_y;
   assign plot_bus.colour = r_colour;
   assign plot_bus.plot   = r_plot;
   assign plot_bus.busy   = r_busy;
   assign pos_x           = r_pos_x;
   assign pos_y           = r_pos_y;
endmodule

// File: tb/tb_soul_box_mover.sv
// Directed bench: DUT A (STEP=1, TICK_DIV=10) and DUT B (STEP=3, TICK_DIV=12) share a key/enable
// stimulus routed by sel; expected plots come from a small position/clamp model.
module tb_soul_box_mover;
   localparam logic [2:0] FG = 3'b100;
   localparam logic [2:0] BG = 3'b000;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1;
   logic       rst_b = 1'b1;
   logic       sel = 1'b0;
   logic       en = 1'b0;
   logic [3:0] keys = 4'hF;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_x = 78;
   int exp_y = 78;
   int step  = 1;

   logic [7:0] pos_x_a, pos_x_b;
   logic [6:0] pos_y_a, pos_y_b;

   soul_box_mover_if #(.X_BITS(8), .Y_BITS(7)) bus_a ();
   soul_box_mover_if #(.X_BITS(8), .Y_BITS(7)) bus_b ();

   soul_box_mover #(.TICK_DIV(10), .STEP(1)) dut_a (
      .clock(clk), .reset(rst_a), .enable(sel ? 1'b0 : en),
      .controlkey(sel ? 4'hF : keys), .plot_bus(bus_a.master),
      .pos_x(pos_x_a), .pos_y(pos_y_a));

   soul_box_mover #(.TICK_DIV(12), .STEP(3)) dut_b (
      .clock(clk), .reset(rst_b), .enable(sel ? en : 1'b0),
      .controlkey(sel ? keys : 4'hF), .plot_bus(bus_b.master),
      .pos_x(pos_x_b), .pos_y(pos_y_b));

   logic [7:0] m_x, m_px;
   logic [6:0] m_y, m_py;
   logic [2:0] m_colour;
   logic       m_plot, m_busy;
   assign m_x      = sel ? bus_b.x      : bus_a.x;
   assign m_y      = sel ? bus_b.y      : bus_a.y;
   assign m_colour = sel ? bus_b.colour : bus_a.colour;
   assign m_plot   = sel ? bus_b.plot   : bus_a.plot;
   assign m_busy   = sel ? bus_b.busy   : bus_a.busy;
   assign m_px     = sel ? pos_x_b      : pos_x_a;
   assign m_py     = sel ? pos_y_b      : pos_y_a;

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reset DUT A for 'hold' cycles, then expect the INIT sprite at (78,78) and idle.
   task automatic test_reset(input int hold);
      logic [18:0] want;
      rst_a = 1'b1;
      keys  = 4'hF;
      repeat (hold) @(negedge clk);
      n_cmp++;
      if ({m_plot, m_busy, m_x, m_y, m_colour, m_px, m_py} !== {1'b0, 1'b1, 8'd0, 7'd0, BG, 8'd78, 7'd78}) begin
         n_bad++;
         $display("FAIL reset_values: plot=%b busy=%b x=%0d y=%0d col=%0d pos=(%0d,%0d), required 0 1 0 0 0 (78,78)",
                  m_plot, m_busy, m_x, m_y, m_colour, m_px, m_py);
      end
      rst_a = 1'b0;
      exp_x = 78;
      exp_y = 78;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         want = {1'b1, FG, 8'(78 + i % 4), 7'(78 + i / 4)};
         n_cmp++;
         if ({m_plot, m_colour, m_x, m_y} !== want) begin
            n_bad++;
            $display("FAIL init_pix[%0d]: got plot=%b col=%0d x=%0d y=%0d, required plot=1 col=%0d x=%0d y=%0d",
                     i, m_plot, m_colour, m_x, m_y, FG, want[14:7], want[6:0]);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({m_plot, m_busy, m_px, m_py} !== {2'b00, 8'd78, 7'd78}) begin
         n_bad++;
         $display("FAIL init_done: plot=%b busy=%b pos=(%0d,%0d), required 0 0 (78,78)", m_plot, m_busy, m_px, m_py);
      end
   endtask

   // One full move with keys k; optional key glitch during ERASE and enable drop at trigger.
   task automatic do_move(input logic [3:0] k, input bit glitch, input bit drop_en);
      int t, ox, oy, nx, ny;
      logic [18:0] want;
      keys = k;
      t = 0;
      while (m_busy !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (m_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL move_start: busy=%b after %0d cycles, required 1", m_busy, t);
         keys = 4'hF;
         return;
      end
      if (drop_en) en = 1'b0;
      ox = exp_x;
      oy = exp_y;
      nx = ox + ((!k[0] && k[3]) ? step : ((!k[3] && k[0]) ? -step : 0));
      ny = oy + ((!k[1] && k[2]) ? step : ((!k[2] && k[1]) ? -step : 0));
      if (nx < 40)  nx = 40;
      if (nx > 116) nx = 116;
      if (ny < 50)  ny = 50;
      if (ny > 106) ny = 106;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         if (glitch && i == 4)  keys = ~k;
         if (glitch && i == 10) keys = k;
         if (i == 16) keys = 4'hF;
         if (i < 16)       want = {1'b1, BG, 8'(ox + i % 4), 7'(oy + i / 4)};
         else if (i > 16)  want = {1'b1, FG, 8'(nx + (i - 17) % 4), 7'(ny + (i - 17) / 4)};
         else              want = 19'd0;
         n_cmp++;
         if ((i == 16) ? (m_plot !== 1'b0) : ({m_plot, m_colour, m_x, m_y} !== want)) begin
            n_bad++;
            $display("FAIL move_pix[%0d]: got plot=%b col=%0d x=%0d y=%0d, required plot=%b col=%0d x=%0d y=%0d",
                     i, m_plot, m_colour, m_x, m_y, want[18], want[17:15], want[14:7], want[6:0]);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({m_busy, m_plot, m_px, m_py} !== {2'b00, 8'(nx), 7'(ny)}) begin
         n_bad++;
         $display("FAIL move_end: busy=%b plot=%b pos=(%0d,%0d), required 0 0 (%0d,%0d)",
                  m_busy, m_plot, m_px, m_py, nx, ny);
      end
      exp_x = nx;
      exp_y = ny;
   endtask

   task automatic test_move_right;
      en = 1'b1;
      do_move(4'b1110, 1'b0, 1'b0);
      do_move(4'b1110, 1'b1, 1'b0);
   endtask

   task automatic test_diagonal;
      do_move(4'b0100, 1'b0, 1'b0);
      do_move(4'b1011, 1'b1, 1'b0);
      do_move(4'b1101, 1'b0, 1'b0);
   endtask

   task automatic test_clamp_right;
      int guard = 0;
      while (exp_x < 116 && guard < 60) begin
         do_move(4'b1110, 1'b0, 1'b0);
         guard++;
      end
      repeat (3) do_move(4'b1110, 1'b0, 1'b0);
   endtask

   task automatic test_enable;
      int active = 0;
      do_move(4'b1110, 1'b0, 1'b1);
      keys = 4'b1110;
      repeat (40) begin
         @(negedge clk);
         if (m_plot || m_busy) active++;
      end
      n_cmp++;
      if (active !== 0) begin
         n_bad++;
         $display("FAIL enable_off: %0d active cycles with enable=0, required 0", active);
      end
      keys = 4'hF;
      en   = 1'b1;
   endtask

   task automatic test_reset_mid_draw;
      int t = 0;
      keys = 4'b1110;
      while (m_busy !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (m_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL middraw_start: busy=%b, required 1", m_busy);
      end
      repeat (20) @(negedge clk);
      test_reset(1);
   endtask

   task automatic test_step3;
      for (int i = 0; i < 14; i++) do_move(4'b0111, 1'b0, 1'b0);
      n_cmp++;
      if (m_px !== 8'd40) begin
         n_bad++;
         $display("FAIL step3_left_clamp: pos_x=%0d, required 40", m_px);
      end
   endtask

   // Key held across a whole move: ticks during it leave exactly one queued move behind.
   task automatic test_pending;
      int t = 0;
      int plots = 0;
      int quiet = 0;
      keys = 4'b1101;
      while (m_busy !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 67; i++) begin
         @(negedge clk);
         if (m_plot) plots++;
         if (i == 50) keys = 4'hF;
         if (i == 33) begin
            n_cmp++;
            if ({m_plot, m_busy} !== 2'b01) begin
               n_bad++;
               $display("FAIL pending_gap: plot=%b busy=%b, required 0 1", m_plot, m_busy);
            end
         end
         if (i == 34) begin
            n_cmp++;
            if ({m_plot, m_colour, m_x, m_y} !== {1'b1, BG, 8'(exp_x), 7'(exp_y + 3)}) begin
               n_bad++;
               $display("FAIL pending_second: plot=%b col=%0d x=%0d y=%0d, required 1 0 %0d %0d",
                        m_plot, m_colour, m_x, m_y, exp_x, exp_y + 3);
            end
         end
      end
      n_cmp++;
      if (plots !== 64) begin
         n_bad++;
         $display("FAIL pending_plots: %0d plots, required 64", plots);
      end
      repeat (60) begin
         @(negedge clk);
         if (m_plot) quiet++;
      end
      n_cmp++;
      if ({quiet, m_px, m_py} !== {32'd0, 8'(exp_x), 7'(exp_y + 6)}) begin
         n_bad++;
         $display("FAIL pending_single: extra plots=%0d pos=(%0d,%0d), required 0 (%0d,%0d)",
                  quiet, m_px, m_py, exp_x, exp_y + 6);
      end
   endtask

   initial begin
      test_reset(3);
      rst_b = 1'b0;
      test_move_right;
      test_diagonal;
      test_clamp_right;
      test_enable;
      test_reset_mid_draw;
      sel   = 1'b1;
      en    = 1'b1;
      step  = 3;
      exp_x = 78;
      exp_y = 78;
      test_step3;
      test_pending;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
